// File: rtl/hr_tx_word_sched.sv
// rtl/hr_tx_word_sched.sv - transmit word scheduler feeding the half-rate 16:4 serializer din
//
// Brings the link up with IDLE -> TRAIN (TRAIN_LEN x TRAIN_PAT) -> SYNC (one SYNC_WORD),
// then RUN, where each word comes from the user stream, a 16-bit-parallel PRBS7, or fixed_pat.
//
// Ports:
//   clk_prbs      parallel word clock
//   rst           synchronous active-high reset
//   en            link enable; low forces IDLE and a zero word
//   mode          run source: 0 user, 1 PRBS7, 2/3 fixed pattern
//   fixed_pat     word sent in fixed mode
//   user_data     user word
//   user_valid    user word valid
//   user_ready    scheduler accepts the user word this cycle (combinational)
//   dout_word     registered word to the mux din, bit 0 serialized first
//   state         0 IDLE, 1 TRAIN, 2 SYNC, 3 RUN
//   link_up       high while in RUN
//   underrun_cnt  saturating count of user underrun cycles
module hr_tx_word_sched #(
  parameter int          TRAIN_LEN = 64,
  parameter logic [15:0] TRAIN_PAT = 16'hF0F0,
  parameter logic [15:0] SYNC_WORD = 16'hB5E3,
  parameter logic [15:0] FILL_WORD = 16'h5555
) (
  input  logic        clk_prbs,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] fixed_pat,
  input  logic [15:0] user_data,
  input  logic        user_valid,
  output logic        user_ready,
  output logic [15:0] dout_word,
  output logic [1:0]  state,
  output logic        link_up,
  output logic [7:0]  underrun_cnt
);

  localparam int CW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam logic [CW-1:0] TRAIN_LAST = CW'(TRAIN_LEN - 1);
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAIN = 2'd1,
    S_SYNC  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t        st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [6:0]    lfsr, lfsr_nxt, lfsr_walk;
  logic [15:0]   prbs_word, word_nxt;
  logic          ur_inc;

  assign state      = st;
  assign user_ready = en && (st == S_RUN) && (mode == 2'd0);

  // Sixteen Fibonacci steps of x^7 + x^6 + 1 per word; the k-th new bit lands in bit k
  // so the LSB-first serializer reproduces the continuous serial PRBS7 stream.
  always_comb begin
    lfsr_walk = lfsr;
    prbs_word = '0;
    for (int k = 0; k < 16; k++) begin
      prbs_word[k] = lfsr_walk[6] ^ lfsr_walk[5];
      lfsr_walk    = {lfsr_walk[5:0], prbs_word[k]};
    end
  end

  // State register and datapath registers
  always_ff @(posedge clk_prbs) begin
    if (rst) begin
      st           <= S_IDLE;
      link_up      <= 1'b0;
      dout_word    <= '0;
      cnt          <= '0;
      lfsr         <= PRBS_SEED;
      underrun_cnt <= '0;
    end else begin
      st        <= st_nxt;
      link_up   <= (st_nxt == S_RUN);
      dout_word <= word_nxt;
      cnt       <= cnt_nxt;
      lfsr      <= lfsr_nxt;
      if (ur_inc && (underrun_cnt != 8'hFF)) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end
    end
  end

  // Next-state logic; a low enable overrides every other transition
  always_comb begin
    st_nxt = st;
    if (!en) begin
      st_nxt = S_IDLE;
    end else begin
      case (st)
        S_IDLE:  st_nxt = (TRAIN_LEN == 0) ? S_SYNC : S_TRAIN;
        S_TRAIN: if (cnt == TRAIN_LAST) st_nxt = S_SYNC;
        S_SYNC:  st_nxt = S_RUN;
        default: st_nxt = S_RUN;
      endcase
    end
  end

  // Output / datapath selection for the word registered at the next edge
  always_comb begin
    word_nxt = '0;
    cnt_nxt  = cnt;
    lfsr_nxt = lfsr;
    ur_inc   = 1'b0;
    if (en) begin
      case (st)
        S_IDLE: cnt_nxt = '0;
        S_TRAIN: begin
          word_nxt = TRAIN_PAT;
          cnt_nxt  = cnt + CW'(1);
        end
        S_SYNC: begin
          word_nxt = SYNC_WORD;
          lfsr_nxt = PRBS_SEED;
        end
        default: begin
          case (mode)
            2'd0: begin
              if (user_valid) begin
                word_nxt = user_data;
              end else begin
                word_nxt = FILL_WORD;
                ur_inc   = 1'b1;
              end
            end
            2'd1: begin
              word_nxt = prbs_word;
              lfsr_nxt = lfsr_walk;
            end
            default: word_nxt = fixed_pat;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hr_tx_word_sched.sv
// tb/tb_hr_tx_word_sched.sv - scoreboard testbench for hr_tx_word_sched
module tb_hr_tx_word_sched;

  localparam int K_DOUT  = 0;
  localparam int K_STATE = 1;
  localparam int K_UR    = 2;
  localparam int K_READY = 3;
  localparam int K_LINK  = 4;

  logic        clk_prbs = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] fixed_pat = 16'h0;
  logic [15:0] user_data = 16'h0;
  logic        user_valid = 1'b0;
  logic        user_ready;
  logic [15:0] dout_word;
  logic [1:0]  state;
  logic        link_up;
  logic [7:0]  underrun_cnt;

  hr_tx_word_sched dut (
    .clk_prbs     (clk_prbs),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .fixed_pat    (fixed_pat),
    .user_data    (user_data),
    .user_valid   (user_valid),
    .user_ready   (user_ready),
    .dout_word    (dout_word),
    .state        (state),
    .link_up      (link_up),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk_prbs = ~clk_prbs;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          mi;
  logic [15:0] act;
  logic [6:0]  ref_lfsr = 7'h7F;
  logic [15:0] hist[127];

  always @(posedge clk_prbs) cyc <= cyc + 1;

  // Monitor: every entry due in the current cycle is compared away from the clock edge
  always @(negedge clk_prbs) begin
    mi = 0;
    while (mi < sb.size()) begin
      if (sb[mi].due == cyc) begin
        case (sb[mi].kind)
          K_DOUT:  act = dout_word;
          K_STATE: act = {14'b0, state};
          K_UR:    act = {8'b0, underrun_cnt};
          K_READY: act = {15'b0, user_ready};
          default: act = {15'b0, link_up};
        endcase
        checks++;
        if (act !== sb[mi].val) begin
          errors++;
          $display("FAIL kind=%0d cycle=%0d got=%h want=%h", sb[mi].kind, cyc, act, sb[mi].val);
        end
        sb.delete(mi);
      end else if (sb[mi].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed kind=%0d due=%0d got=none want=%h", sb[mi].kind, sb[mi].due, sb[mi].val);
        sb.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  task automatic push(input int due, input int kind, input logic [15:0] val);
    exp_t e;
    e.due = due;
    e.kind = kind;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_now(input int kind, input logic [15:0] val);
    push(cyc, kind, val);
  endtask

  task automatic expect_next(input int kind, input logic [15:0] val);
    push(cyc + 1, kind, val);
  endtask

  task automatic tick();
    @(posedge clk_prbs);
    #1;
  endtask

  // Apply one cycle of inputs; w is the word expected on dout_word after the edge
  task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic [15:0] fp,
                       input logic [15:0] d, input logic v, input logic [15:0] w);
    rst = r;
    en = e;
    mode = m;
    fixed_pat = fp;
    user_data = d;
    user_valid = v;
    expect_next(K_DOUT, w);
    tick();
  endtask

  // Reference PRBS7 x^7+x^6+1 seeded 7'h7F, 16 serial bits packed LSB first
  function automatic logic [15:0] prbs_next();
    logic [15:0] w;
    logic        b;
    for (int k = 0; k < 16; k++) begin
      b = ref_lfsr[6] ^ ref_lfsr[5];
      ref_lfsr = {ref_lfsr[5:0], b};
      w[k] = b;
    end
    return w;
  endfunction

  task automatic bringup(input logic [1:0] m, input logic [15:0] fp);
    expect_next(K_STATE, 16'd1);
    drive(0, 1, m, fp, 16'h0, 0, 16'h0000);
    for (int i = 0; i < 64; i++) begin
      if (i == 5) begin
        expect_now(K_READY, 16'd0);
        expect_now(K_LINK, 16'd0);
      end
      if (i == 63) expect_next(K_STATE, 16'd2);
      drive(0, 1, m, fp, 16'h0, 0, 16'hF0F0);
    end
    expect_next(K_STATE, 16'd3);
    expect_next(K_LINK, 16'd1);
    drive(0, 1, m, fp, 16'h0, 0, 16'hB5E3);
    ref_lfsr = 7'h7F;
  endtask

  initial begin
    tick();
    tick();
    expect_now(K_DOUT, 16'h0);
    expect_now(K_STATE, 16'd0);
    expect_now(K_READY, 16'd0);
    expect_now(K_UR, 16'd0);
    expect_now(K_LINK, 16'd0);
    drive(0, 0, 0, 16'h0, 16'h0, 0, 16'h0000);
    expect_now(K_READY, 16'd0);

    bringup(2'd0, 16'h0);

    // user stream back-to-back
    expect_now(K_READY, 16'd1);
    for (int i = 1; i <= 16; i++) drive(0, 1, 0, 16'h0, 16'(i), 1, 16'(i));
    expect_now(K_UR, 16'd0);

    // three-cycle underrun gap
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 16'h0, 16'hDEAD, 0, 16'h5555);
    drive(0, 1, 0, 16'h0, 16'h0011, 1, 16'h0011);
    expect_now(K_UR, 16'd3);
    for (int i = 0; i < 300; i++) drive(0, 1, 0, 16'h0, 16'h0, 0, 16'h5555);
    expect_now(K_UR, 16'd255);

    // PRBS7 run and period-127 repeat
    for (int i = 0; i < 127; i++) begin
      hist[i] = prbs_next();
      drive(0, 1, 1, 16'h0, 16'h0, 1, hist[i]);
      if (i == 0) expect_now(K_READY, 16'd0);
    end
    for (int i = 0; i < 127; i++) begin
      void'(prbs_next());
      drive(0, 1, 1, 16'h0, 16'h0, 1, hist[i]);
    end
    expect_now(K_UR, 16'd255);

    // fixed mode, reserved mode, then PRBS continues where it left off
    for (int i = 0; i < 4; i++) drive(0, 1, 2, 16'h1234, 16'h0, 0, 16'h1234);
    drive(0, 1, 3, 16'hABCD, 16'h0, 0, 16'hABCD);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 16'h1234, 16'h0, 0, prbs_next());
    expect_now(K_STATE, 16'd3);

    // enable dropped in RUN
    expect_next(K_STATE, 16'd0);
    expect_next(K_LINK, 16'd0);
    drive(0, 0, 1, 16'h0, 16'h0, 1, 16'h0000);

    // enable dropped during training word 10
    drive(0, 1, 2, 16'h0F0F, 16'h0, 0, 16'h0000);
    for (int i = 0; i < 10; i++) drive(0, 1, 2, 16'h0F0F, 16'h0, 0, 16'hF0F0);
    expect_next(K_STATE, 16'd0);
    drive(0, 0, 2, 16'h0F0F, 16'h0, 0, 16'h0000);

    // full retrain, fixed words, then reset in RUN
    bringup(2'd2, 16'h0F0F);
    drive(0, 1, 2, 16'h0F0F, 16'h0, 0, 16'h0F0F);
    drive(0, 1, 2, 16'h0F0F, 16'h0, 0, 16'h0F0F);
    expect_next(K_STATE, 16'd0);
    expect_next(K_LINK, 16'd0);
    expect_next(K_UR, 16'd0);
    drive(1, 1, 2, 16'h0F0F, 16'h0, 0, 16'h0000);
    expect_now(K_READY, 16'd0);
    drive(0, 0, 0, 16'h0, 16'h0, 0, 16'h0000);

    tick();
    tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover entries got=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hr_tx_word_sched.md
Name: hr_tx_word_sched

Overview:
- Transmit word scheduler in the clk_prbs domain. It produces the 16-bit parallel word that feeds the half-rate 16:4 serializer mux on its din input.
- It sequences link bring-up in three steps: idle, then a training preamble, then a single sync word.
- After bring-up it selects one run-time source per word: user stream (valid/ready), internal parallel PRBS7, or a programmable fixed pattern.
- Underruns on the user stream are counted.

Parameters:
TRAIN_LEN, 64, number of training words sent before the sync word (0 = skip training)
TRAIN_PAT, 16'hF0F0, training word
SYNC_WORD, 16'hB5E3, single delimiter word between training and run
FILL_WORD, 16'h5555, word sent when the user source underruns

Ports:
clk_prbs  in  1  parallel word clock (divided clock, same domain as the mux din capture)
rst  in  1  reset, synchronous, active-high
en  in  1  link enable; low forces IDLE
mode  in  2  run source: 0 user, 1 PRBS7, 2 fixed, 3 reserved (behaves as 2)
fixed_pat  in  16  word sent in fixed mode
user_data  in  16  user word
user_valid  in  1  user word valid
user_ready  out  1  scheduler accepts user word this cycle
dout_word  out  16  registered word to the mux din; bit 0 is serialized first
state  out  2  0 IDLE, 1 TRAIN, 2 SYNC, 3 RUN
link_up  out  1  high while in RUN
underrun_cnt  out  8  saturating count of user underrun cycles

Behaviour:
- One clock: clk_prbs. Reset is synchronous and active-high on rst. All state changes occur on the clk_prbs rising edge.
- Reset values:
  - dout_word = 0, state = IDLE, link_up = 0, underrun_cnt = 0, training counter = 0.
  - LFSR = 7'h7F.
  - user_ready = 0, since it is combinational and state is IDLE.
- dout_word is registered. The word chosen in cycle n appears at dout_word in cycle n+1, so latency is 1 cycle.
- FSM transitions:
  - IDLE: output 0. If en = 1, go to TRAIN and clear the counter. If TRAIN_LEN = 0, go directly to SYNC.
  - TRAIN: output TRAIN_PAT and increment the counter. After the TRAIN_LEN-th training word, go to SYNC. Exactly TRAIN_LEN words are sent.
  - SYNC: output SYNC_WORD for exactly 1 cycle, go to RUN, and reseed the LFSR to 7'h7F.
  - RUN: select the source by mode every cycle and stay in RUN.
  - Any state: en = 0 means the next state is IDLE and the next dout_word is 0. That takes priority over all other transitions.
  - Re-asserting en restarts the full TRAIN/SYNC sequence.
- link_up = 1 exactly when state = RUN. It is a registered decode of state.
- User handshake:
  - user_ready = en AND state = RUN AND mode = 0. It is combinational and depends on no user input.
  - A transfer occurs when user_valid AND user_ready; user_data is registered to dout_word.
  - If ready is high and valid is low: dout_word = FILL_WORD, and underrun_cnt increments, saturating at 255.
  - While user_ready is low, user_valid is ignored and nothing is consumed.
- PRBS7 (x^7 + x^6 + 1, Fibonacci):
  - Advances 16 bit-steps per clock, only in RUN with mode = 1.
  - dout_word[k] = k-th new output bit of that cycle, k = 0 to 15.
  - The serial stream across words is a continuous PRBS7 with period 127.
  - The LFSR holds its value when not advancing. Leaving PRBS mode and returning continues the sequence; no reseed.
- Fixed mode: dout_word = fixed_pat, sampled each cycle.
- A mode change in RUN takes effect on the next word. No retraining and no filler insertion.
- Simultaneous events:
  - rst beats everything.
  - en = 0 beats a mode change and a pending user transfer: no transfer occurs, because ready is already low once en is low.
  - The counter increment and the SYNC transition occur in the same edge.
- underrun_cnt is cleared only by rst.

Test Plan:
- Reset, then en = 1 with TRAIN_LEN = 64 → exactly 64 × 16'hF0F0, then one 16'hB5E3, then link_up = 1 on the following cycle. Before the enable, dout_word = 0 and user_ready = 0.
- Mode 0, user_valid high, data 16'h0001, 16'h0002, …, 16'h0010 back-to-back → same 16 words on dout_word with 1-cycle latency; underrun_cnt = 0.
- Mode 0 with user_valid low for 3 cycles in the middle of the stream → 3 × 16'h5555 inserted, underrun_cnt = 3. Holding user_valid low for 300 cycles → underrun_cnt = 255.
- Mode 1 for 127 words → serialized LSB-first bits match a reference PRBS7 seeded 7'h7F, continuous across words. The 16-bit word sequence repeats with period 127.
- Mode 2 with fixed_pat = 16'h1234, then switch to mode 1 mid-run → 16'h1234 until the switch, then PRBS on the next word; state stays RUN.
- en dropped during TRAIN (word 10) and during RUN → dout_word = 0 next cycle, state = IDLE. Re-asserting en produces the full 64-word training again. rst asserted in RUN → all outputs at reset values next cycle.
